heater_delay_chain: RTL and testbench

HEATER_DELAY_CHAIN -- requirements
Module: heater_delay_chain

---
 rtl/heater_delay_chain.sv | 127 ++++++++++++
 tb/tb_heater_delay_chain.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/heater_delay_chain.sv
// heater_delay_chain: LFSR generators pushed through per-channel RAM delay lines and checked against delayed LFSR replicas
// Ports:
//   clk_i        rising-edge clock
//   reset_n_i    asynchronous active-low reset, release synchronised by two flops
//   enable_i     run control; low returns to IDLE and reloads seeds
//   err_clear_i  synchronous clear of err_chan_o/err_count_o (wins over a new mismatch)
//   inject_i     single-cycle flip of bit 0 of channel 0's write word (HEATER_ERR_INJECT_EN only)
//   locked_o     high while in CHECK
//   error_o      OR of err_chan_o
//   err_chan_o   sticky per-channel mismatch flags
//   err_count_o  saturating count of cycles with any mismatch
// Config macro: HEATER_ERR_INJECT_EN adds inject_i and its write-data flip.
module heater_delay_chain #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 1024,
    parameter int CHANNELS = 4,
    parameter int PIPE     = 8
) (
    input  logic                clk_i,
    input  logic                reset_n_i,
    input  logic                enable_i,
    input  logic                err_clear_i,
`ifdef HEATER_ERR_INJECT_EN
    input  logic                inject_i,
`endif
    output logic                locked_o,
    output logic                error_o,
    output logic [CHANNELS-1:0] err_chan_o,
    output logic [15:0]         err_count_o
);
    localparam int L  = DEPTH + 1 + PIPE;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(L);
    typedef enum logic [1:0] {IDLE, FILL, CHECK} state_t;
    state_t              state_q;
    logic [1:0]          rst_sync_q;
    logic                rst_n;
    logic [AW-1:0]       ptr_q;
    logic [CW-1:0]       cnt_q;
    logic                locked_q;
    logic [CHANNELS-1:0] err_chan_q, err_chan_d, miss;
    logic [15:0]         err_count_q, err_count_d;
    logic                run, inj;
    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? 32'h80200003 : 32'h0);
    endfunction
    function automatic logic [WIDTH-1:0] word(input logic [31:0] s);
        return WIDTH'({4{s}});
    endfunction
    // Assertion is immediate through the flop clears; release waits two edges.
    always_ff @(posedge clk_i or negedge reset_n_i)
        if (!reset_n_i) rst_sync_q <= '0;
        else rst_sync_q <= {rst_sync_q[0], 1'b1};
    assign rst_n = rst_sync_q[1];
    assign run   = state_q != IDLE;
`ifdef HEATER_ERR_INJECT_EN
    assign inj = inject_i;
`else
    assign inj = 1'b0;
`endif
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            ptr_q    <= '0;
            locked_q <= 1'b0;
        end else if (!enable_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            ptr_q    <= '0;
            locked_q <= 1'b0;
        end else begin
            if (run) ptr_q <= ptr_q + 1'b1;
            case (state_q)
                IDLE: begin
                    state_q <= FILL;
                    cnt_q   <= '0;
                end
                FILL:
                    if (cnt_q == CW'(L - 1)) begin
                        state_q  <= CHECK;
                        locked_q <= 1'b1;
                    end else cnt_q <= cnt_q + 1'b1;
                default: ;
            endcase
        end
    end
    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        localparam logic [31:0] SEED = 32'hACE10000 | 32'(c + 1);
        logic [31:0]      gen_q, chk_q;
        logic [WIDTH-1:0] mem [DEPTH];
        logic [WIDTH-1:0] pipe_q [PIPE+1];
        logic [WIDTH-1:0] wr_d;
        assign wr_d = word(gen_q) ^ WIDTH'(inj && c == 0);
        always_ff @(posedge clk_i)
            if (run) mem[ptr_q] <= wr_d;
        // pipe_q[0] is the registered RAM read (old contents: read-before-write).
        always_ff @(posedge clk_i or negedge rst_n)
            if (!rst_n) begin
                gen_q <= SEED;
                chk_q <= SEED;
                for (int s = 0; s <= PIPE; s++) pipe_q[s] <= '0;
            end else begin
                gen_q <= !enable_i ? SEED : run ? lfsr_next(gen_q) : gen_q;
                chk_q <= !enable_i ? SEED : state_q == CHECK ? lfsr_next(chk_q) : chk_q;
                if (run) begin
                    pipe_q[0] <= mem[ptr_q];
                    for (int s = 1; s <= PIPE; s++) pipe_q[s] <= pipe_q[s-1];
                end
            end
        assign miss[c] = state_q == CHECK && pipe_q[PIPE] != word(chk_q);
    end
    assign err_chan_d  = err_clear_i ? '0 : err_chan_q | miss;
    assign err_count_d = err_clear_i ? '0 : (|miss && !(&err_count_q)) ? err_count_q + 16'd1 : err_count_q;
    always_ff @(posedge clk_i or negedge rst_n)
        if (!rst_n) begin
            err_chan_q  <= '0;
            err_count_q <= '0;
        end else begin
            err_chan_q  <= err_chan_d;
            err_count_q <= err_count_d;
        end
    assign locked_o    = locked_q;
    assign error_o     = |err_chan_q;
    assign err_chan_o  = err_chan_q;
    assign err_count_o = err_count_q;
endmodule

// File: tb/tb_heater_delay_chain.sv
// tb_heater_delay_chain: directed scoreboard bench for heater_delay_chain (DEPTH=16, PIPE=2, CHANNELS=2, L=19)
`timescale 1ns/1ps
module tb_heater_delay_chain;
    localparam int CH = 2;
    logic clk = 0, reset_n = 0, enable = 0, err_clear = 0;
`ifdef HEATER_ERR_INJECT_EN
    logic inject = 0;
`endif
    logic          locked, error;
    logic [CH-1:0] err_chan;
    logic [15:0]   err_count;
    int cyc = 0, n_vec = 0, n_bad = 0;
    typedef struct {
        int            at;
        logic          lk;
        logic          er;
        logic [CH-1:0] ch;
        logic [15:0]   cnt;
        string         nm;
    } exp_t;
    exp_t sb[$];
    exp_t m;

    heater_delay_chain #(.WIDTH(32), .DEPTH(16), .CHANNELS(CH), .PIPE(2)) dut (
        .clk_i(clk),
        .reset_n_i(reset_n),
        .enable_i(enable),
        .err_clear_i(err_clear),
`ifdef HEATER_ERR_INJECT_EN
        .inject_i(inject),
`endif
        .locked_o(locked),
        .error_o(error),
        .err_chan_o(err_chan),
        .err_count_o(err_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic goto(input int k);
        while (cyc < k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_at(input int at, input logic lk, input logic er, input logic [CH-1:0] ch,
                             input logic [15:0] cnt, input string nm);
        exp_t e;
        e.at = at; e.lk = lk; e.er = er; e.ch = ch; e.cnt = cnt; e.nm = nm;
        sb.push_back(e);
    endtask

    // Monitor: outputs are presented every cycle; pop every expectation due by now.
    always @(negedge clk)
        while (sb.size() > 0 && sb[0].at <= cyc) begin
            m = sb.pop_front();
            n_vec++;
            if ({locked, error, err_chan, err_count} !== {m.lk, m.er, m.ch, m.cnt}) begin
                n_bad++;
                $display("FAIL %s @cycle %0d: got locked=%b error=%b err_chan=%b err_count=%h, want locked=%b error=%b err_chan=%b err_count=%h",
                         m.nm, cyc, locked, error, err_chan, err_count, m.lk, m.er, m.ch, m.cnt);
            end
        end

    initial begin
        #2ms;
        $display("FAIL timeout: run did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int e, r, x, b;
`ifdef HEATER_ERR_INJECT_EN
        int i, j, s;
`endif
        expect_at(2, 0, 0, 2'b00, 16'd0, "reset");
        goto(3);
        reset_n = 1;
        // Lock: enable in cycle e -> FILL from e+1, CHECK from e+20.
        e = 10;
        expect_at(e + 1, 0, 0, 2'b00, 16'd0, "fill_start");
        expect_at(e + 19, 0, 0, 2'b00, 16'd0, "pre_lock");
        expect_at(e + 20, 1, 0, 2'b00, 16'd0, "lock");
        for (int k = 1; k <= 8; k++) expect_at(e + 20 + 250 * k, 1, 0, 2'b00, 16'd0, "no_err");
        expect_at(e + 2031, 1, 0, 2'b00, 16'd0, "clear_keeps_lock");
        goto(e);
        enable = 1;
        goto(e + 2030);
        err_clear = 1;
        goto(e + 2031);
        err_clear = 0;
        r = e + 2100;
`ifdef HEATER_ERR_INJECT_EN
        // Single injection: word of cycle i reaches the checker at i+19, flag at i+20.
        i = e + 2050;
        expect_at(i + 19, 1, 0, 2'b00, 16'd0, "inj_pre");
        expect_at(i + 20, 1, 1, 2'b01, 16'd1, "inj_hit");
        expect_at(i + 60, 1, 1, 2'b01, 16'd1, "inj_once");
        goto(i);
        inject = 1;
        goto(i + 1);
        inject = 0;
        // Clear coincident with the detect cycle j+19.
        j = e + 2150;
        expect_at(j + 19, 1, 1, 2'b01, 16'd1, "race_pre");
        expect_at(j + 20, 1, 0, 2'b00, 16'd0, "race_clear");
        expect_at(j + 40, 1, 0, 2'b00, 16'd0, "race_after");
        goto(j);
        inject = 1;
        goto(j + 1);
        inject = 0;
        goto(j + 19);
        err_clear = 1;
        goto(j + 20);
        err_clear = 0;
        // Saturation: mismatches every cycle from s+19 to s+65618.
        s = e + 2300;
        expect_at(s + 119, 1, 1, 2'b01, 16'd100, "sat_ramp");
        expect_at(s + 65560, 1, 1, 2'b01, 16'hFFFF, "sat_reach");
        expect_at(s + 65700, 1, 1, 2'b01, 16'hFFFF, "sat_hold");
        expect_at(s + 65711, 1, 0, 2'b00, 16'd0, "sat_clear");
        goto(s);
        inject = 1;
        goto(s + 65600);
        inject = 0;
        goto(s + 65710);
        err_clear = 1;
        goto(s + 65711);
        err_clear = 0;
        r = s + 65800;
`endif
        // Restart: enable low for cycle r, high again from r+1 -> CHECK from r+21.
        expect_at(r, 1, 0, 2'b00, 16'd0, "pre_restart");
        expect_at(r + 1, 0, 0, 2'b00, 16'd0, "unlock");
        expect_at(r + 20, 0, 0, 2'b00, 16'd0, "relock_wait");
        expect_at(r + 21, 1, 0, 2'b00, 16'd0, "relock");
        expect_at(r + 300, 1, 0, 2'b00, 16'd0, "relock_clean");
        goto(r);
        enable = 0;
        goto(r + 1);
        enable = 1;
        // Reset mid-CHECK: outputs drop at once; release at x+2 -> CHECK from x+24.
        x = r + 350;
        expect_at(x, 0, 0, 2'b00, 16'd0, "async_rst");
        expect_at(x + 23, 0, 0, 2'b00, 16'd0, "rst_relock_wait");
        expect_at(x + 24, 1, 0, 2'b00, 16'd0, "rst_relock");
        expect_at(x + 60, 1, 0, 2'b00, 16'd0, "rst_clean");
        goto(x);
        reset_n = 0;
        goto(x + 2);
        reset_n = 1;
        // Reset mid-FILL at fill count 7 (cycle b+8); release at b+10 -> CHECK from b+32.
        b = x + 100;
        expect_at(b + 8, 0, 0, 2'b00, 16'd0, "fill_rst");
        expect_at(b + 9, 0, 0, 2'b00, 16'd0, "fill_rst_hold");
        expect_at(b + 31, 0, 0, 2'b00, 16'd0, "fill_relock_wait");
        expect_at(b + 32, 1, 0, 2'b00, 16'd0, "fill_relock");
        expect_at(b + 500, 1, 0, 2'b00, 16'd0, "fill_relock_clean");
        goto(b - 1);
        enable = 0;
        goto(b);
        enable = 1;
        goto(b + 8);
        reset_n = 0;
        goto(b + 10);
        reset_n = 1;
        goto(b + 502);
        if (sb.size() != 0) begin
            n_bad += sb.size();
            $display("FAIL scoreboard_drain: %0d expectations pending, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
